// File: rtl/dotprod_pkg.sv
// Shared definitions for the dot-product accumulator: FSM state codes and width helpers.
// Latency: n/a (constants and elaboration-time functions only).
// Backpressure: n/a.
package dotprod_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Number of packed elements per input word
    function automatic int lanes(input int data_width, input int elem_width);
        return data_width / elem_width;
    endfunction

    // Full-precision width of one word's sum of lane products
    function automatic int lane_sum_width(input int data_width, input int elem_width);
        return 2 * elem_width + clog2(lanes(data_width, elem_width));
    endfunction

endpackage

// File: rtl/lane_mac.sv
// Multiplies two packed words lane by lane and sums the products into one unsigned value.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the sum is registered.
module lane_mac
    import dotprod_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ELEM_WIDTH     = 8,
    parameter int LANE_SUM_WIDTH = lane_sum_width(DATA_WIDTH, ELEM_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0]     a_data,
    input  logic [DATA_WIDTH-1:0]     b_data,
    output logic [LANE_SUM_WIDTH-1:0] lane_sum
);

    localparam int LANES = lanes(DATA_WIDTH, ELEM_WIDTH);

    logic [LANE_SUM_WIDTH-1:0] sum;

    // Per-lane unsigned products summed at full width so no carry is lost;
    // synthesis is free to rebalance the chain into a tree.
    always_comb begin
        sum = '0;
        for (int k = 0; k < LANES; k++) begin
            sum = sum + LANE_SUM_WIDTH'(a_data[k*ELEM_WIDTH +: ELEM_WIDTH])
                      * LANE_SUM_WIDTH'(b_data[k*ELEM_WIDTH +: ELEM_WIDTH]);
        end
    end

    assign lane_sum = sum;

endmodule

// File: rtl/dot_product_acc.sv
// Accumulates the lane-wise dot product of VEC_LEN packed word pairs and returns one scalar.
// Latency: result_valid is high in the 3rd cycle after the edge accepting the last beat.
// Backpressure: in_ready only in ACCUM; result is held stable until result_ready.
module dot_product_acc
    import dotprod_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ELEM_WIDTH = 8,
    parameter int VEC_LEN    = 32,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic [ACC_WIDTH-1:0]  result,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic                  busy
);

    localparam int LSW   = lane_sum_width(DATA_WIDTH, ELEM_WIDTH);
    localparam int CNT_W = (VEC_LEN > 1) ? clog2(VEC_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(VEC_LEN - 1);

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [LSW-1:0]       lane_sum;
    logic [LSW-1:0]       s1_sum_q, s1_sum_d;
    logic                 s1_valid_q, s1_valid_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] result_q, result_d;
    logic                 result_valid_q, result_valid_d;
    logic                 beat;

    lane_mac #(
        .DATA_WIDTH     (DATA_WIDTH),
        .ELEM_WIDTH     (ELEM_WIDTH),
        .LANE_SUM_WIDTH (LSW)
    ) u_lane_mac (
        .a_data   (a_data),
        .b_data   (b_data),
        .lane_sum (lane_sum)
    );

    assign beat = in_valid && (state_q == ST_ACCUM);

    // Control FSM: beat counting, drain slot, result capture and output handshake
    always_comb begin
        state_d        = state_q;
        beat_cnt_d     = beat_cnt_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_ACCUM;
                    beat_cnt_d = '0;
                end
            end
            ST_ACCUM: begin
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // the last stage-1 sum lands in acc at the end of this cycle
                state_d = ST_DONE;
            end
            ST_DONE: begin
                // first DONE cycle snapshots the settled accumulator
                if (!result_valid_q) begin
                    result_d       = acc_q;
                    result_valid_d = 1'b1;
                end else if (result_ready) begin
                    result_valid_d = 1'b0;
                    state_d        = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Two-stage datapath: stage 1 registers a word's lane sum, stage 2 adds it into acc
    always_comb begin
        s1_valid_d = beat;
        s1_sum_d   = beat ? lane_sum : s1_sum_q;
        acc_d      = acc_q;
        if (s1_valid_q) begin
            // wraps modulo 2^ACC_WIDTH by construction
            acc_d = acc_q + ACC_WIDTH'(s1_sum_q);
        end
        if ((state_q == ST_IDLE) && start) begin
            acc_d = '0;
        end
    end

    // State and pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            beat_cnt_q     <= '0;
            s1_sum_q       <= '0;
            s1_valid_q     <= 1'b0;
            acc_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            beat_cnt_q     <= beat_cnt_d;
            s1_sum_q       <= s1_sum_d;
            s1_valid_q     <= s1_valid_d;
            acc_q          <= acc_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign in_ready     = (state_q == ST_ACCUM);
    assign busy         = (state_q != ST_IDLE);
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_dot_product_acc.sv
// Self-checking bench: scoreboard of expected dot products, two DUT widths (32 and 16-bit acc).
// Latency: checks result_valid timing after the last beat.
// Backpressure: exercises bubbles on the input and a stalled result consumer.
module tb_dot_product_acc;

    localparam int DW = 32;
    localparam int EW = 8;
    localparam int VL = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] a_data = '0;
    logic [31:0] b_data = '0;
    logic        result_ready = 1'b1;

    logic        in_ready, result_valid, busy;
    logic [31:0] result;
    logic        in_ready16, result_valid16, busy16;
    logic [15:0] result16;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q [$];
    logic [15:0] exp16_q [$];
    logic [31:0] va [VL];
    logic [31:0] vb [VL];
    logic        held_vld = 1'b0;
    logic [31:0] held_res = '0;

    always #5 clk = ~clk;

    dot_product_acc #(
        .DATA_WIDTH (DW), .ELEM_WIDTH (EW), .VEC_LEN (VL), .ACC_WIDTH (32)
    ) dut (
        .clk (clk), .rst_n (rst_n), .start (start),
        .in_valid (in_valid), .in_ready (in_ready),
        .a_data (a_data), .b_data (b_data),
        .result (result), .result_valid (result_valid),
        .result_ready (result_ready), .busy (busy)
    );

    dot_product_acc #(
        .DATA_WIDTH (DW), .ELEM_WIDTH (EW), .VEC_LEN (VL), .ACC_WIDTH (16)
    ) dut16 (
        .clk (clk), .rst_n (rst_n), .start (start),
        .in_valid (in_valid), .in_ready (in_ready16),
        .a_data (a_data), .b_data (b_data),
        .result (result16), .result_valid (result_valid16),
        .result_ready (result_ready), .busy (busy16)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     tag, obs, obs, exp, exp, $time);
        end
    endtask

    // Reference: unsigned sum of the four 8-bit lane products of one word pair
    function automatic logic [31:0] word_dot(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s;
        s = '0;
        for (int k = 0; k < 4; k++) begin
            s = s + {24'd0, a[8*k +: 8]} * {24'd0, b[8*k +: 8]};
        end
        return s;
    endfunction

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        a_data   = a;
        b_data   = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("beat_accept", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        @(negedge clk);
        while (!result_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("valid_seen", {31'd0, result_valid}, 32'd1);
    endtask

    // Start a run over va/vb with 'gap' idle cycles between beats; expectation is queued
    // once the last beat is driven.
    task automatic run_vec(input int gap, input bit chk_lat);
        logic [31:0] exp_sum;
        int          lat;
        exp_sum = '0;
        do_start();
        for (int i = 0; i < VL; i++) begin
            send_beat(va[i], vb[i]);
            exp_sum = exp_sum + word_dot(va[i], vb[i]);
            if (i < VL - 1) begin
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        exp_q.push_back(exp_sum);
        exp16_q.push_back(exp_sum[15:0]);
        if (chk_lat) begin
            lat = 0;
            while (lat < 20) begin
                @(negedge clk);
                lat++;
                if (result_valid) break;
            end
            check_eq("latency", 32'(lat), 32'd3);
            @(negedge clk);
            check_eq("valid_one_cycle", {31'd0, result_valid}, 32'd0);
            check_eq("busy_after_hs", {31'd0, busy}, 32'd0);
        end
    endtask

    // Scoreboard for the 32-bit DUT plus hold/stability checks while stalled
    always @(negedge clk) begin
        if (rst_n) begin
            if (held_vld) begin
                check_eq("valid_held", {31'd0, result_valid}, 32'd1);
                check_eq("result_stable", result, held_res);
            end
            if (result_valid && result_ready) begin
                if (exp_q.size() == 0) check_eq("spurious_result", {31'd0, result_valid}, 32'd0);
                else                   check_eq("result", result, exp_q.pop_front());
            end
            held_vld <= result_valid && !result_ready;
            held_res <= result;
        end else begin
            held_vld <= 1'b0;
        end
    end

    // Scoreboard for the 16-bit-accumulator DUT
    always @(negedge clk) begin
        if (rst_n && result_valid16 && result_ready) begin
            if (exp16_q.size() == 0) check_eq("spurious_result16", {31'd0, result_valid16}, 32'd0);
            else                     check_eq("result16", {16'd0, result16}, {16'd0, exp16_q.pop_front()});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_valid", {31'd0, result_valid}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_result16", {16'd0, result16}, 32'd0);
        check_eq("rst_busy16", {30'd0, busy16, in_ready16}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: basic run, result 120 with latency check
        for (int i = 0; i < VL; i++) begin
            va[i] = 32'h01020304;
            vb[i] = 32'h01020304;
        end
        run_vec(0, 1'b1);

        // 2: bubbles on input, consumer stalled for several cycles; result 64
        result_ready = 1'b0;
        for (int i = 0; i < VL; i++) begin
            va[i] = {8'(i + 1), 8'(i + 2), 8'(i + 3), 8'(i + 4)};
            vb[i] = 32'h01010101;
        end
        run_vec(1, 1'b0);
        wait_valid();
        repeat (5) begin
            @(negedge clk);
            check_eq("stall_valid", {31'd0, result_valid}, 32'd1);
        end
        @(posedge clk);
        #1;
        result_ready = 1'b1;
        wait_idle();

        // 3: maximum operands; 16-bit accumulator wraps to 0xE010
        for (int i = 0; i < VL; i++) begin
            va[i] = 32'hFFFFFFFF;
            vb[i] = 32'hFFFFFFFF;
        end
        run_vec(0, 1'b0);
        wait_idle();

        // 4: in_valid in IDLE, start during ACCUM and during DONE are ignored
        for (int i = 0; i < VL; i++) begin
            va[i] = 32'h01020304;
            vb[i] = 32'h01020304;
        end
        a_data   = 32'hFFFFFFFF;
        b_data   = 32'hFFFFFFFF;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("idle_in_ready", {31'd0, in_ready}, 32'd0);
            check_eq("idle_busy", {31'd0, busy}, 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        do_start();
        send_beat(va[0], vb[0]);
        send_beat(va[1], vb[1]);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_beat(va[2], vb[2]);
        send_beat(va[3], vb[3]);
        exp_q.push_back(32'd120);
        exp16_q.push_back(16'd120);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (!busy) break;
            start = 1'b1;
        end
        start = 1'b0;
        check_eq("done_start_idle", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        check_eq("no_restart", {31'd0, busy}, 32'd0);

        // 5: asynchronous reset after two beats, then a clean run
        do_start();
        send_beat(va[0], vb[0]);
        send_beat(va[1], vb[1]);
        #3 rst_n = 1'b0;
        #1;
        check_eq("arst_busy", {31'd0, busy}, 32'd0);
        check_eq("arst_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("arst_valid", {31'd0, result_valid}, 32'd0);
        check_eq("arst_result", result, 32'd0);
        check_eq("arst_result16", {16'd0, result16}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("post_rst_valid", {31'd0, result_valid}, 32'd0);
        @(posedge clk);
        #1;
        run_vec(0, 1'b0);
        wait_idle();

        // 6: back-to-back runs, second vector all zeros
        run_vec(0, 1'b0);
        wait_idle();
        for (int i = 0; i < VL; i++) begin
            va[i] = '0;
            vb[i] = '0;
        end
        run_vec(0, 1'b0);
        wait_idle();

        repeat (3) @(negedge clk);
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        check_eq("sb16_drained", 32'(exp16_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dot_product_acc.md
Name: dot_product_acc

Overview:
- Downstream consumer of two memory-reader stages (vector A and vector B).
- Each DATA_WIDTH word carries LANES packed unsigned elements.
- The block multiplies the A and B words lane by lane, sums the lanes, and accumulates over VEC_LEN word pairs.
- It then presents the scalar dot product on a valid/ready output, driven by a small FSM with a 2-stage datapath.

Parameters:
DATA_WIDTH, 32, width of each packed input word (matches the reader data_out width).
ELEM_WIDTH, 8, width of one unsigned element; LANES = DATA_WIDTH/ELEM_WIDTH (must divide exactly).
VEC_LEN, 32, word pairs per dot product (matches reader MEM_SIZE); must be >= 1.
ACC_WIDTH, 32, accumulator/result width; must be >= 2*ELEM_WIDTH + clog2(LANES*VEC_LEN).

Ports:
clk  input  1  single clock, all logic on rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  one-cycle request to begin a new dot product; honoured only in IDLE.
in_valid  input  1  a_data/b_data carry a valid word pair this cycle.
in_ready  output  1  block accepts a pair this cycle; a beat = in_valid & in_ready.
a_data  input  DATA_WIDTH  packed elements of vector A; lane k = bits [k*ELEM_WIDTH +: ELEM_WIDTH].
b_data  input  DATA_WIDTH  packed elements of vector B, same lane layout.
result  output  ACC_WIDTH  final dot product; stable while result_valid is high.
result_valid  output  1  result available.
result_ready  input  1  consumer takes the result; handshake = result_valid & result_ready.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; beat_cnt=0; acc=0; stage-1 valid=0; result=0; result_valid=0; in_ready=0; busy=0. Reset mid-operation aborts silently; no partial result is emitted.
- States: IDLE, ACCUM, DRAIN, DONE.
- IDLE:
  - in_ready=0.
  - start=1 -> acc<=0, beat_cnt<=0, go to ACCUM.
  - in_valid in IDLE is ignored.
- ACCUM:
  - in_ready=1.
  - On each beat: stage 1 registers lane_sum = sum over k of a_k*b_k (unsigned, full 2*ELEM_WIDTH+clog2(LANES) width) with s1_valid=1; beat_cnt increments.
  - The beat with beat_cnt==VEC_LEN-1 moves to DRAIN; in_ready drops the next cycle.
  - No beat (in_valid=0) means no stage-1 update and s1_valid=0; bubbles are allowed anywhere.
- Stage 2 (any state): s1_valid=1 -> acc <= acc + zero-extended lane_sum. Wrap modulo 2^ACC_WIDTH; no saturation and no overflow flag.
- DRAIN: one cycle for the last stage-2 add, then go to DONE.
- DONE:
  - result <= acc, captured on entry.
  - result_valid=1, held with result stable until result_ready=1.
  - On handshake: result_valid<=0, go to IDLE.
- Latency: result_valid rises 3 cycles after the clock edge that accepts the last beat.
- start while busy=1 is ignored, with no effect on count or acc.
- start and result handshake in the same DONE cycle: handshake completes and start is ignored; a new start is needed in IDLE.
- busy = (state != IDLE).
- Throughput: one word pair per cycle in ACCUM.

Decomposition:
- Shared package (dotprod_pkg): state encoding constants (IDLE=0, ACCUM=1, DRAIN=2, DONE=3); function clog2; derived LANES and LANE_SUM_WIDTH.
- One sub-module: lane_mac, purely combinational. It takes a_data and b_data and produces lane_sum (LANES multipliers plus an adder tree), so lane width and count change in one place.
- dot_product_acc holds the FSM, counter, pipeline registers and output handshake.

Test Plan (bench parameters: VEC_LEN=4, defaults otherwise):
1. Basic
   - Stimulus: start, then 4 back-to-back beats, each a=b={8'd1,8'd2,8'd3,8'd4}; result_ready=1.
   - Response: per-word sum 30; result=120; result_valid for exactly 1 cycle, 3 cycles after the last beat; then IDLE, busy=0.
2. Bubbles plus backpressure
   - Stimulus: beats i=0..3 with a={1+i,2+i,3+i,4+i}, b=all lanes 1, in_valid low every other cycle; result_ready held low 5 cycles.
   - Response: result=10+14+18+22=64, held stable with result_valid high until result_ready rises.
3. Max values and wrap
   - Stimulus: ACC_WIDTH=16, 4 beats, a=b=32'hFFFFFFFF.
   - Response: per word 4*65025=260100; total 1040400 mod 65536 = 57360 (16'hE010).
4. Ignored inputs
   - Stimulus: in_valid=1 in IDLE; start pulsed during ACCUM and during DONE.
   - Response: in_ready=0 in IDLE, no count change; result unaffected (120 for the test-1 data); IDLE reached after handshake.
5. Reset mid-operation
   - Stimulus: assert rst_n=0 asynchronously after 2 beats; release; start; 4 beats of test-1 data.
   - Response: all outputs 0 immediately on reset; no result_valid before the new run; new result=120 (no stale acc).
6. Back-to-back runs
   - Stimulus: start in the cycle after the result handshake; feed a second vector of all zeros.
   - Response: second result=0; the first run's result is unaffected.
